// File: rtl/uvma_axil_xact_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uvma_axil_xact_ctrl
// Brief    : Single-outstanding AXI-Lite master sequencer (req/rsp to AW/W/B, AR/R).
//            Optional watchdog: define UVMA_AXIL_XACT_CTRL_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module uvma_axil_xact_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_aw_done;
  logic                    r_w_done;
  logic                    w_aw_done_nxt;
  logic                    w_w_done_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_WIDTH-1:0]   r_wstrb;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [1:0]              r_rsp_resp;
  logic                    w_accept;
  logic                    w_b_fire;
  logic                    w_r_fire;
  logic                    w_timeout;

  assign req_ready = (r_state == IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;

  // AW and W are tracked separately so their handshakes may land in any order.
  assign awvalid = (r_state == WR_REQ) && !r_aw_done;
  assign wvalid  = (r_state == WR_REQ) && !r_w_done;
  assign bready  = (r_state == WR_RESP);
  assign arvalid = (r_state == RD_REQ);
  assign rready  = (r_state == RD_RESP);

  assign awaddr = r_addr;
  assign araddr = r_addr;
  assign wdata  = r_wdata;
  assign wstrb  = r_wstrb;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;

  assign w_b_fire = bready && bvalid;
  assign w_r_fire = rready && rvalid;

`ifdef UVMA_AXIL_XACT_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_tmo_cnt <= '0;
    end else if (r_state != IDLE) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Fires in the cycle the count of busy cycles reaches TIMEOUT_CYCLES.
  assign w_timeout = (r_state != IDLE) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt   = req_we ? WR_REQ : RD_REQ;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      WR_REQ: begin
        w_aw_done_nxt = r_aw_done || (awvalid && awready);
        w_w_done_nxt  = r_w_done || (wvalid && wready);
        if (w_aw_done_nxt && w_w_done_nxt) w_state_nxt = WR_RESP;
      end
      WR_RESP: if (bvalid)  w_state_nxt = IDLE;
      RD_REQ:  if (arready) w_state_nxt = RD_RESP;
      RD_RESP: if (rvalid)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_timeout) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_aw_done   <= w_aw_done_nxt;
      r_w_done    <= w_w_done_nxt;
      r_rsp_valid <= w_b_fire || w_r_fire || w_timeout;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wstrb <= req_wstrb;
      end
      // A real response arriving on the watchdog's final cycle takes priority.
      if (w_b_fire) begin
        r_rsp_rdata <= '0;
        r_rsp_resp  <= bresp;
      end else if (w_r_fire) begin
        r_rsp_rdata <= rdata;
        r_rsp_resp  <= rresp;
      end else if (w_timeout) begin
        r_rsp_rdata <= '0;
        r_rsp_resp  <= 2'b10;
      end
    end
  end

endmodule
`default_nettype wire
